rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-port arbiter for the 32×64-bit general-purpose register file. The file has one write port, but two producers need it: the in-order pipeline writeback stage and the long-latency execution unit (mul/div). This block grants the port to the pipeline by default and buffers long-latency results in a small FIFO, draining them in idle writeback slots. A starvation counter requests a pipeline writeback bubble so that buffered results always retire.

## Interface
Parameters:
- `DEPTH`, 2: long-latency FIFO entries (power of 2, ≥2).
- `STARVE_MAX`, 8: consecutive blocked cycles before `pipe_stall` asserts.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `nrst`  in  1  reset, asynchronous and active-low.
- `wb_valid`  in  1  pipeline writeback request; always accepted, no ready.
- `wb_addr`  in  5  pipeline destination register.
- `wb_data`  in  64  pipeline result.
- `ll_valid`  in  1  long-latency result valid.
- `ll_ready`  out  1  FIFO can accept; equals `!full`, driven from registered count.
- `ll_addr`  in  5  long-latency destination register.
- `ll_data`  in  64  long-latency result.
- `rf_wr_en`  out  1  register file write enable (registered).
- `rf_wr_addr`  out  5  register file write address (registered).
- `rf_wr_data`  out  64  register file write data (registered).
- `pipe_stall`  out  1  request that the pipeline suppress `wb_valid` (registered).
- `fifo_count`  out  $clog2(DEPTH)+1  number of buffered entries.
- `protocol_err`  out  1  sticky flag; set when `wb_valid` is seen while `pipe_stall` is high.

## Operation
- **Enqueue:** an `ll_valid && ll_ready` handshake pushes `{ll_addr, ll_data}`. When `ll_addr == 0` the handshake completes but nothing is pushed.
- **Grant, evaluated each cycle:**
  - If `wb_valid`, the pipeline wins and the FIFO holds.
  - Else, if the FIFO is non-empty, pop the head and write it.
  - Else, idle.
- **Pipeline writes to x0:** `rf_wr_en` stays low, but the slot still counts as used by the pipeline.
- **Full FIFO:** a push and a pop in the same cycle are not allowed when the FIFO is full, because `ll_ready` is already low. A push and a pop together when partially full leave the count unchanged.
- **Starvation counter (`starve_cnt`):**
  - Increments when the FIFO is non-empty and `wb_valid` is high.
  - Clears on any pop and whenever the FIFO is empty.
  - Saturates at `STARVE_MAX`.
  - `pipe_stall` is 1 in the cycle after `starve_cnt` reaches `STARVE_MAX`, and stays 1 until the next pop.
- **`pipe_stall` contract:** upstream keeps `wb_valid` low while `pipe_stall` is high. If that is violated, the pipeline still wins the port and `protocol_err` sets and stays set until reset.
- **Ordering:** WAW/RAW ordering between the two sources is not this block's concern; the issue scoreboard guarantees it. FIFO entries retire in push order.

## Timing
- **Reset values (asynchronous, all outputs and state):** `rf_wr_en`=0, `rf_wr_addr`=0, `rf_wr_data`=0, `pipe_stall`=0, `protocol_err`=0, `fifo_count`=0, `ll_ready`=1, FIFO pointers=0, `starve_cnt`=0.
- **Pipeline latency:** `wb_valid` in cycle N gives `rf_wr_*` valid in cycle N+1, so the register file captures at the end of N+1.
- **Long-latency latency:** a push at the edge ending cycle N makes the head eligible in N+1. If that slot is free, `rf_wr_*` appears in N+2, giving a 2-cycle minimum.
- **Ready timing:** `ll_ready` falls in the cycle after the push that fills the FIFO, and rises in the cycle after the pop that frees an entry.
- **Reset mid-operation:** buffered entries are discarded, and no write is issued after reset asserts.

## Structure
- **Shared package `rf_pkg`:**
  - `XLEN`=64 and `REG_ADDR_W`=5.
  - `typedef struct packed {logic [REG_ADDR_W-1:0] addr; logic [XLEN-1:0] data;} rf_wr_req_t`.
  - Used by the register file and the writeback stages.
- **Sub-module `rf_wb_fifo`:** a synchronous FIFO of `rf_wr_req_t` with push/pop, `full`/`empty`, count, and asynchronous active-low reset. The arbiter, starvation counter and output registers live in `rf_wb_arbiter`.

## Test plan
- **Reset:** reset, then release.
  - `rf_wr_en`=0, `ll_ready`=1, `fifo_count`=0 and `pipe_stall`=0.
  - Assert `nrst` low mid-cycle while the FIFO holds 2 entries: the count goes to 0 immediately and no write follows.
- **Pipeline only:** `wb_valid` with x5 = 0xDEAD_BEEF in cycle 3.
  - `rf_wr_en`=1, addr 5, data 0xDEADBEEF in cycle 4.
  - `wb_addr`=0 gives `rf_wr_en`=0.
- **Long-latency into an idle port:** `ll_valid` x7 = 0x1234 in cycle 3 with no `wb_valid`.
  - Write of x7 = 0x1234 in cycle 5.
  - Two back-to-back pushes retire in order, in cycles 5 and 6.
- **Contention and full FIFO:** `wb_valid` held high with `ll` pushes of x1 then x2.
  - `fifo_count`=2 and `ll_ready`=0 while `wb` writes continue.
  - Drop `wb_valid`: x1 then x2 are written, and `ll_ready` returns to 1.
- **Starvation:** `STARVE_MAX`=8, 1 entry buffered, `wb_valid` held high.
  - `pipe_stall`=1 after 8 blocked cycles.
  - Drop `wb_valid`: the entry is written and `pipe_stall` returns to 0 the next cycle.
  - Keeping `wb_valid` high instead sets `protocol_err`=1 and leaves it set.
- **x0 drop:** an `ll` push with `ll_addr`=0 completes the handshake, `fifo_count` stays 0 and no write occurs.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file types: write-port request layout used by the writeback
// stages and the register file itself.
package rf_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } rf_wr_req_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle between the writeback producers and the register-file write-port arbiter.
interface rf_wb_arbiter_if import rf_pkg::*; #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [XLEN-1:0]       wb_data;
    logic                  ll_valid;
    logic                  ll_ready;
    logic [REG_ADDR_W-1:0] ll_addr;
    logic [XLEN-1:0]       ll_data;
    logic                  rf_wr_en;
    logic [REG_ADDR_W-1:0] rf_wr_addr;
    logic [XLEN-1:0]       rf_wr_data;
    logic                  pipe_stall;
    logic [CW-1:0]         fifo_count;
    logic                  protocol_err;

    modport master (
        output wb_valid, wb_addr, wb_data, ll_valid, ll_addr, ll_data,
        input  ll_ready, rf_wr_en, rf_wr_addr, rf_wr_data, pipe_stall,
               fifo_count, protocol_err
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, ll_valid, ll_addr, ll_data,
        output ll_ready, rf_wr_en, rf_wr_addr, rf_wr_data, pipe_stall,
               fifo_count, protocol_err
    );

endinterface

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO buffering long-latency register-file write requests.
module rf_wb_fifo import rf_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          push,
    input  rf_wr_req_t                    push_data,
    input  logic                          pop,
    output rf_wr_req_t                    head,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(DEPTH):0]        count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    rf_wr_req_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency
// results are buffered and drained in idle slots, with a starvation stall request.
module rf_wb_arbiter import rf_pkg::*; #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic            clk,
    input  logic            nrst,
    rf_wb_arbiter_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    rf_wr_req_t            push_req;
    rf_wr_req_t            head;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [CW-1:0]         count;
    logic [SW-1:0]         starve_cnt;
    logic [SW-1:0]         starve_nxt;
    logic                  wr_en_q;
    logic [REG_ADDR_W-1:0] wr_addr_q;
    logic [XLEN-1:0]       wr_data_q;
    logic                  pipe_stall_q;
    logic                  protocol_err_q;

    // x0 results complete the handshake but are never buffered.
    assign push     = bus.ll_valid && !full && (bus.ll_addr != '0);
    assign pop      = !bus.wb_valid && !empty;
    assign push_req = '{addr: bus.ll_addr, data: bus.ll_data};

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push      (push),
        .push_data (push_req),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        starve_nxt = starve_cnt;
        if (empty || pop)
            starve_nxt = '0;
        else if (bus.wb_valid && starve_cnt != STARVE_LIM)
            starve_nxt = starve_cnt + SW'(1);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            starve_cnt     <= '0;
            pipe_stall_q   <= 1'b0;
            protocol_err_q <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
        end else begin
            starve_cnt   <= starve_nxt;
            pipe_stall_q <= (starve_nxt == STARVE_LIM);
            if (bus.wb_valid && pipe_stall_q) protocol_err_q <= 1'b1;
            wr_en_q <= bus.wb_valid ? (bus.wb_addr != '0) : !empty;
            if (bus.wb_valid) begin
                wr_addr_q <= bus.wb_addr;
                wr_data_q <= bus.wb_data;
            end else if (pop) begin
                wr_addr_q <= head.addr;
                wr_data_q <= head.data;
            end
        end
    end

    assign bus.ll_ready     = !full;
    assign bus.fifo_count   = count;
    assign bus.rf_wr_en     = wr_en_q;
    assign bus.rf_wr_addr   = wr_addr_q;
    assign bus.rf_wr_data   = wr_data_q;
    assign bus.pipe_stall   = pipe_stall_q;
    assign bus.protocol_err = protocol_err_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter (DEPTH=2, STARVE_MAX=8).
module tb_rf_wb_arbiter;

    logic clk;
    logic nrst;
    int   checks;
    int   failures;

    rf_wb_arbiter_if #(.DEPTH(2)) bus ();

    rf_wb_arbiter #(.DEPTH(2), .STARVE_MAX(8)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [4:0] wa, input logic [63:0] wd,
                         input logic lv, input logic [4:0] la, input logic [63:0] ld);
        bus.wb_valid = wv;
        bus.wb_addr  = wa;
        bus.wb_data  = wd;
        bus.ll_valid = lv;
        bus.ll_addr  = la;
        bus.ll_data  = ld;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [4:0] a, input logic [63:0] d);
        chk({tag, "_en"}, 64'(bus.rf_wr_en), 64'(en));
        if (en) begin
            chk({tag, "_addr"}, 64'(bus.rf_wr_addr), 64'(a));
            chk({tag, "_data"}, bus.rf_wr_data, d);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        nrst     = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        // Reset values
        #2 nrst = 1'b0;
        #1;
        chk("rst_count_async", 64'(bus.fifo_count), 64'd0);
        tick();
        tick();
        chk("rst_wr_en",   64'(bus.rf_wr_en), 64'd0);
        chk("rst_wr_addr", 64'(bus.rf_wr_addr), 64'd0);
        chk("rst_wr_data", bus.rf_wr_data, 64'd0);
        chk("rst_ready",   64'(bus.ll_ready), 64'd1);
        chk("rst_count",   64'(bus.fifo_count), 64'd0);
        chk("rst_stall",   64'(bus.pipe_stall), 64'd0);
        chk("rst_perr",    64'(bus.protocol_err), 64'd0);
        nrst = 1'b1;
        tick();

        // Pipeline only: one-cycle latency, x0 suppressed
        drive(1, 5, 64'hDEAD_BEEF, 0, 0, 0);
        tick();
        chk_wr("pipe_x5", 1, 5, 64'hDEAD_BEEF);
        drive(1, 0, 64'h1, 0, 0, 0);
        tick();
        chk_wr("pipe_x0", 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk_wr("pipe_idle", 0, 0, 0);

        // Long-latency into an idle port: two-cycle latency
        drive(0, 0, 0, 1, 7, 64'h1234);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("ll_cnt1", 64'(bus.fifo_count), 64'd1);
        chk_wr("ll_not_yet", 0, 0, 0);
        tick();
        chk_wr("ll_x7", 1, 7, 64'h1234);
        chk("ll_cnt0", 64'(bus.fifo_count), 64'd0);

        // Back-to-back pushes retire in order
        drive(0, 0, 0, 1, 8, 64'hAA);
        tick();
        drive(0, 0, 0, 1, 9, 64'hBB);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk_wr("b2b_x8", 1, 8, 64'hAA);
        chk("b2b_cnt_hold", 64'(bus.fifo_count), 64'd1);
        tick();
        chk_wr("b2b_x9", 1, 9, 64'hBB);
        chk("b2b_cnt0", 64'(bus.fifo_count), 64'd0);
        tick();
        chk_wr("b2b_idle", 0, 0, 0);

        // Contention: fill FIFO while pipeline owns the port
        drive(1, 3, 64'h33, 1, 1, 64'h11);
        tick();
        chk_wr("cont_wb3", 1, 3, 64'h33);
        chk("cont_cnt1", 64'(bus.fifo_count), 64'd1);
        chk("cont_rdy1", 64'(bus.ll_ready), 64'd1);
        drive(1, 4, 64'h44, 1, 2, 64'h22);
        tick();
        chk_wr("cont_wb4", 1, 4, 64'h44);
        chk("cont_cnt2", 64'(bus.fifo_count), 64'd2);
        chk("cont_rdy0", 64'(bus.ll_ready), 64'd0);
        drive(1, 3, 64'h35, 1, 6, 64'h66);
        tick();
        chk_wr("cont_wb3b", 1, 3, 64'h35);
        chk("cont_full_hold", 64'(bus.fifo_count), 64'd2);
        chk("cont_stall0", 64'(bus.pipe_stall), 64'd0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk_wr("cont_x1", 1, 1, 64'h11);
        chk("cont_rdy_back", 64'(bus.ll_ready), 64'd1);
        chk("cont_cnt_dec", 64'(bus.fifo_count), 64'd1);
        tick();
        chk_wr("cont_x2", 1, 2, 64'h22);
        chk("cont_cnt_empty", 64'(bus.fifo_count), 64'd0);
        tick();
        chk_wr("cont_idle", 0, 0, 0);

        // Starvation with compliant upstream
        drive(1, 11, 64'hB0, 1, 10, 64'hA0A0);
        tick();
        drive(1, 11, 64'hB1, 0, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("starve_b%0d_stall0", i), 64'(bus.pipe_stall), 64'd0);
        end
        tick();
        chk("starve_b8_stall1", 64'(bus.pipe_stall), 64'd1);
        chk("starve_perr0", 64'(bus.protocol_err), 64'd0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk_wr("starve_x10", 1, 10, 64'hA0A0);
        chk("starve_stall_clr", 64'(bus.pipe_stall), 64'd0);
        chk("starve_cnt0", 64'(bus.fifo_count), 64'd0);
        chk("starve_perr_still0", 64'(bus.protocol_err), 64'd0);

        // Starvation with protocol violation
        drive(1, 11, 64'hC0, 1, 12, 64'hC12);
        tick();
        drive(1, 11, 64'hC1, 0, 0, 0);
        for (int i = 1; i <= 8; i++) tick();
        chk("viol_stall1", 64'(bus.pipe_stall), 64'd1);
        drive(1, 13, 64'hD13, 0, 0, 0);
        tick();
        chk("viol_perr1", 64'(bus.protocol_err), 64'd1);
        chk_wr("viol_pipe_wins", 1, 13, 64'hD13);
        chk("viol_cnt_hold", 64'(bus.fifo_count), 64'd1);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk_wr("viol_x12", 1, 12, 64'hC12);
        chk("viol_stall_clr", 64'(bus.pipe_stall), 64'd0);
        tick();
        chk("viol_perr_sticky", 64'(bus.protocol_err), 64'd1);

        // x0 long-latency result is dropped
        drive(0, 0, 0, 1, 0, 64'hFF);
        #1;
        chk("x0_ready", 64'(bus.ll_ready), 64'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("x0_cnt0", 64'(bus.fifo_count), 64'd0);
        tick();
        chk_wr("x0_nowrite", 0, 0, 0);

        // Reset mid-operation with two entries buffered
        drive(1, 14, 64'hE0, 1, 13, 64'h1313);
        tick();
        drive(1, 14, 64'hE1, 1, 14, 64'h1414);
        tick();
        chk("midrst_cnt2", 64'(bus.fifo_count), 64'd2);
        drive(0, 0, 0, 0, 0, 0);
        #2 nrst = 1'b0;
        #1;
        chk("midrst_cnt_async", 64'(bus.fifo_count), 64'd0);
        chk("midrst_wr_en", 64'(bus.rf_wr_en), 64'd0);
        chk("midrst_ready", 64'(bus.ll_ready), 64'd1);
        chk("midrst_perr_clr", 64'(bus.protocol_err), 64'd0);
        tick();
        chk("midrst_wr_en_held", 64'(bus.rf_wr_en), 64'd0);
        nrst = 1'b1;
        tick();
        chk("midrst_no_write", 64'(bus.rf_wr_en), 64'd0);
        chk("midrst_cnt_after", 64'(bus.fifo_count), 64'd0);
        tick();
        chk("midrst_no_write2", 64'(bus.rf_wr_en), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
